// File: rtl/stream_demux2.sv
// stream_demux2: 2-way streaming demultiplexer.
//
// One valid/ready input stream is steered, per packet, to one of two output streams.
// in_sel is sampled on the first beat of a packet and the destination is held until the
// beat carrying in_last. Each output owns a 2-entry {last, data} FIFO, so a stalled
// consumer only back-pressures packets headed for it.
//
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   in_data/in_valid/in_last/in_sel       input stream and per-packet destination
//   in_ready                              input accepted this cycle (no path from out*_ready)
//   out0_data/out0_valid/out0_last        channel 0 stream, out0_ready from consumer
//   out1_data/out1_valid/out1_last        channel 1 stream, out1_ready from consumer
//   pkt_cnt0/pkt_cnt1                     packets pushed per channel (optional, see below)
//
// Optional feature: define STREAM_DEMUX2_PKTCNT_EN to add the per-channel packet counters
// pkt_cnt0/pkt_cnt1 (CW bits, wrapping). Without it the counters and ports are absent.

module stream_demux2 #(
    parameter int unsigned N  = 18,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  in_data,
    input  logic          in_valid,
    input  logic          in_last,
    input  logic          in_sel,
    output logic          in_ready,
    output logic [N-1:0]  out0_data,
    output logic          out0_valid,
    output logic          out0_last,
    input  logic          out0_ready,
    output logic [N-1:0]  out1_data,
    output logic          out1_valid,
    output logic          out1_last,
    input  logic          out1_ready
`ifdef STREAM_DEMUX2_PKTCNT_EN
    ,
    output logic [CW-1:0] pkt_cnt0,
    output logic [CW-1:0] pkt_cnt1
`endif
);

    typedef enum logic [1:0] {StIdle, StRoute0, StRoute1} state_e;

    state_e state_q, state_d;

    // Per-channel FIFO: storage, read pointer and occupancy (0..2).
    logic [N:0] mem_q [2][2];
    logic [N:0] mem_d [2][2];
    logic       rd_q  [2];
    logic       rd_d  [2];
    logic [1:0] cnt_q [2];
    logic [1:0] cnt_d [2];

    logic       dest;
    logic       accept;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] out_valid;
    logic [1:0] out_ready;

    // Destination is fixed by the state mid-packet; in IDLE it follows in_sel.
    always_comb begin
        dest = in_sel;
        unique case (state_q)
            StRoute0: dest = 1'b0;
            StRoute1: dest = 1'b1;
            default:  dest = in_sel;
        endcase
    end

    // Depends only on registered occupancy, state and in_sel: no path from out*_ready.
    assign in_ready = !rst && (cnt_q[dest] != 2'd2);
    assign accept   = in_valid && in_ready;

    assign out_valid[0] = (cnt_q[0] != 2'd0);
    assign out_valid[1] = (cnt_q[1] != 2'd0);
    assign out_ready    = {out1_ready, out0_ready};

    assign out0_valid              = out_valid[0];
    assign {out0_last, out0_data}  = mem_q[0][rd_q[0]];
    assign out1_valid              = out_valid[1];
    assign {out1_last, out1_data}  = mem_q[1][rd_q[1]];

    always_comb begin
        state_d = state_q;
        if (accept) begin
            unique case (state_q)
                StIdle: begin
                    if (!in_last) begin
                        state_d = in_sel ? StRoute1 : StRoute0;
                    end
                end
                StRoute0, StRoute1: begin
                    if (in_last) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        push  = 2'b00;
        pop   = 2'b00;
        for (int c = 0; c < 2; c++) begin
            push[c] = accept && (dest == c[0]);
            pop[c]  = out_valid[c] && out_ready[c];
            // Tail slot is rd ^ cnt[0]; push never happens at cnt == 2.
            if (push[c]) begin
                mem_d[c][rd_q[c] ^ cnt_q[c][0]] = {in_last, in_data};
            end
            if (pop[c]) begin
                rd_d[c] = ~rd_q[c];
            end
            cnt_d[c] = cnt_q[c] + 2'(push[c]) - 2'(pop[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            for (int c = 0; c < 2; c++) begin
                rd_q[c]  <= 1'b0;
                cnt_q[c] <= 2'd0;
                // Storage is cleared so data/last read as 0 straight after reset.
                mem_q[c][0] <= '0;
                mem_q[c][1] <= '0;
            end
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
        end
    end

`ifdef STREAM_DEMUX2_PKTCNT_EN
    logic [CW-1:0] pkt_cnt_q [2];
    logic [CW-1:0] pkt_cnt_d [2];

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        for (int c = 0; c < 2; c++) begin
            if (push[c] && in_last) begin
                pkt_cnt_d[c] = pkt_cnt_q[c] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q[0] <= '0;
            pkt_cnt_q[1] <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_cnt0 = pkt_cnt_q[0];
    assign pkt_cnt1 = pkt_cnt_q[1];
`endif

endmodule

// File: tb/tb_stream_demux2.sv
// Testbench for stream_demux2: directed scenarios plus a randomized run, checked against a
// queue-based reference model (per-channel lists of words sent and words received).

module tb_stream_demux2;

    localparam int unsigned N = 18;
`ifdef STREAM_DEMUX2_PKTCNT_EN
    localparam int unsigned CW = 2;
`else
    localparam int unsigned CW = 16;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] in_data;
    logic         in_valid, in_last, in_sel, in_ready;
    logic [N-1:0] out0_data, out1_data;
    logic         out0_valid, out0_last, out0_ready;
    logic         out1_valid, out1_last, out1_ready;
`ifdef STREAM_DEMUX2_PKTCNT_EN
    logic [CW-1:0] pkt_cnt0, pkt_cnt1;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: words expected per channel, words actually delivered, packet state.
    logic [N:0] sent0[$], sent1[$], recv0[$], recv1[$];
    bit         in_pkt   = 1'b0;
    bit         cur_dest = 1'b0;

    always #5 clk = ~clk;

    stream_demux2 #(.N(N), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_sel     (in_sel),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_last  (out0_last),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_last  (out1_last),
        .out1_ready (out1_ready)
`ifdef STREAM_DEMUX2_PKTCNT_EN
        ,
        .pkt_cnt0   (pkt_cnt0),
        .pkt_cnt1   (pkt_cnt1)
`endif
    );

    function automatic int occ(input bit c);
        return c ? (sent1.size() - recv1.size()) : (sent0.size() - recv0.size());
    endfunction

    function automatic bit exp_ready();
        bit d;
        d = in_pkt ? cur_dest : in_sel;
        return !rst && (occ(d) < 2);
    endfunction

    // Advance one clock: sample handshakes on the falling edge, update the model after the
    // rising edge, and return 1 time unit later.
    task automatic tick();
        bit         acc, d, p0, p1;
        logic [N:0] w0, w1, wi;
        @(negedge clk);
        d   = in_pkt ? cur_dest : in_sel;
        acc = in_valid && in_ready;
        p0  = out0_valid && out0_ready;
        p1  = out1_valid && out1_ready;
        w0  = {out0_last, out0_data};
        w1  = {out1_last, out1_data};
        wi  = {in_last, in_data};
        @(posedge clk);
        if (rst) begin
            sent0.delete(); sent1.delete(); recv0.delete(); recv1.delete();
            in_pkt = 1'b0;
        end else begin
            if (acc) begin
                if (d) sent1.push_back(wi);
                else   sent0.push_back(wi);
                if (in_last) begin
                    in_pkt = 1'b0;
                end else if (!in_pkt) begin
                    in_pkt   = 1'b1;
                    cur_dest = d;
                end
            end
            if (p0) recv0.push_back(w0);
            if (p1) recv1.push_back(w1);
        end
        #1;
    endtask

    task automatic drain();
        in_valid   = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_last = 1'b0; in_data = 18'h3ffff;
        out0_ready = 1'b1; out1_ready = 1'b1;
        tick();
        tick();
        checks++; if (in_ready !== 1'b0) begin failures++;
            $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        checks++; if ({out0_valid, out0_last, out0_data} !== '0) begin failures++;
            $display("FAIL reset_out0 got=%b/%b/%h want=0", out0_valid, out0_last, out0_data); end
        checks++; if ({out1_valid, out1_last, out1_data} !== '0) begin failures++;
            $display("FAIL reset_out1 got=%b/%b/%h want=0", out1_valid, out1_last, out1_data); end
`ifdef STREAM_DEMUX2_PKTCNT_EN
        checks++; if ({pkt_cnt0, pkt_cnt1} !== '0) begin failures++;
            $display("FAIL reset_pkt_cnt got=%0d/%0d want=0", pkt_cnt0, pkt_cnt1); end
`endif
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++;
            $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_single_beat();
        in_valid = 1'b1; in_data = 18'h00011; in_sel = 1'b0; in_last = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++;
            $display("FAIL single_ready got=%b want=1", in_ready); end
        tick();
        in_data = 18'h00022; in_sel = 1'b1;
        #1;
        checks++; if ({out0_valid, out0_last, out0_data} !== {2'b11, 18'h00011}) begin failures++;
            $display("FAIL single_out0 got=%b/%b/%h want=1/1/00011",
                     out0_valid, out0_last, out0_data); end
        checks++; if (out1_valid !== 1'b0) begin failures++;
            $display("FAIL single_out1_early got=%b want=0", out1_valid); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if ({out1_valid, out1_last, out1_data} !== {2'b11, 18'h00022}) begin failures++;
            $display("FAIL single_out1 got=%b/%b/%h want=1/1/00022",
                     out1_valid, out1_last, out1_data); end
        checks++; if (out0_valid !== 1'b0) begin failures++;
            $display("FAIL single_out0_popped got=%b want=0", out0_valid); end
        drain();
    endtask

    task automatic test_packet_hold();
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = N'(i); in_last = (i == 4);
            in_sel   = (i == 1) ? 1'b1 : i[0];
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++;
                $display("FAIL hold_ready beat=%0d got=%b want=1", i, in_ready); end
            tick();
            in_valid = 1'b0;
            #1;
            checks++; if ({out1_valid, out1_last, out1_data} !== {1'b1, (i == 4), N'(i)}) begin
                failures++;
                $display("FAIL hold_out1 beat=%0d got=%b/%b/%h want=1/%0d/%h",
                         i, out1_valid, out1_last, out1_data, (i == 4), i); end
            checks++; if (out0_valid !== 1'b0) begin failures++;
                $display("FAIL hold_out0_quiet beat=%0d got=%b want=0", i, out0_valid); end
        end
        drain();
        sent0.delete(); sent1.delete(); recv0.delete(); recv1.delete();
    endtask

    task automatic test_backpressure();
        logic [N:0] exp0 [4];
        exp0[0] = {1'b0, 18'h000a1}; exp0[1] = {1'b0, 18'h000a2};
        exp0[2] = {1'b1, 18'h000a3}; exp0[3] = {1'b1, 18'h000a4};
        out0_ready = 1'b0; out1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_last = 1'b0; in_data = 18'h000a1;
        #1; checks++; if (in_ready !== 1'b1) begin failures++;
            $display("FAIL bp_beat1_ready got=%b want=1", in_ready); end
        tick();
        in_data = 18'h000a2; in_sel = 1'b1;
        #1; checks++; if (in_ready !== 1'b1) begin failures++;
            $display("FAIL bp_beat2_ready got=%b want=1", in_ready); end
        tick();
        in_data = 18'h000a3; in_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1; checks++; if (in_ready !== 1'b0) begin failures++;
                $display("FAIL bp_stalled_ready cyc=%0d got=%b want=0", k, in_ready); end
            tick();
        end
        out0_ready = 1'b1;
        #1; checks++; if (in_ready !== 1'b0) begin failures++;
            $display("FAIL bp_no_comb_path got=%b want=0", in_ready); end
        tick();
        #1; checks++; if (in_ready !== 1'b1) begin failures++;
            $display("FAIL bp_release_ready got=%b want=1", in_ready); end
        tick();
        // Refill out0 with a single-beat packet while stalled, then test isolation.
        out0_ready = 1'b0; in_data = 18'h000a4; in_sel = 1'b0;
        #1; checks++; if (in_ready !== 1'b1) begin failures++;
            $display("FAIL bp_a4_ready got=%b want=1", in_ready); end
        tick();
        in_data = 18'h000b1; in_sel = 1'b0;
        #1; checks++; if (in_ready !== 1'b0) begin failures++;
            $display("FAIL bp_full_sel0 got=%b want=0", in_ready); end
        in_sel = 1'b1;
        #1; checks++; if (in_ready !== 1'b1) begin failures++;
            $display("FAIL bp_isolation_sel1 got=%b want=1", in_ready); end
        tick();
        drain();
        checks++; if (recv0.size() != 4 || recv1.size() != 1) begin failures++;
            $display("FAIL bp_counts got=%0d/%0d want=4/1", recv0.size(), recv1.size()); end
        for (int i = 0; i < 4 && i < recv0.size(); i++) begin
            checks++; if (recv0[i] !== exp0[i]) begin failures++;
                $display("FAIL bp_out0_word idx=%0d got=%h want=%h", i, recv0[i], exp0[i]); end
        end
        if (recv1.size() > 0) begin
            checks++; if (recv1[0] !== {1'b1, 18'h000b1}) begin failures++;
                $display("FAIL bp_out1_word got=%h want=%h", recv1[0], {1'b1, 18'h000b1}); end
        end
        sent0.delete(); sent1.delete(); recv0.delete(); recv1.delete();
    endtask

    task automatic test_throughput();
        out0_ready = 1'b1; out1_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = N'(32'h100 + i); in_last = (i == 15);
            in_sel = (i == 0) ? 1'b1 : 1'($urandom);
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++;
                $display("FAIL tput_bubble beat=%0d got=%b want=1", i, in_ready); end
            checks++; if (occ(1'b1) > 1) begin failures++;
                $display("FAIL tput_count1 beat=%0d got=%0d want<=1", i, occ(1'b1)); end
            tick();
        end
        drain();
        checks++; if (recv1.size() != 16 || recv0.size() != 0) begin failures++;
            $display("FAIL tput_counts got=%0d/%0d want=0/16", recv0.size(), recv1.size()); end
        for (int i = 0; i < 16 && i < recv1.size(); i++) begin
            checks++; if (recv1[i] !== {(i == 15), N'(32'h100 + i)}) begin failures++;
                $display("FAIL tput_word idx=%0d got=%h", i, recv1[i]); end
        end
        sent0.delete(); sent1.delete(); recv0.delete(); recv1.delete();
    endtask

    task automatic test_mid_reset();
        out0_ready = 1'b0; out1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_last = 1'b0; in_data = 18'h000c1;
        tick();
        in_data = 18'h000c2; rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if ({out0_valid, out0_data, out1_valid} !== '0) begin failures++;
            $display("FAIL midrst_empty got=%b/%h/%b want=0", out0_valid, out0_data, out1_valid); end
        out0_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b1; in_last = 1'b1; in_data = 18'h000d1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++;
            $display("FAIL midrst_ready got=%b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if ({out1_valid, out1_data, out0_valid} !== {1'b1, 18'h000d1, 1'b0}) begin
            failures++;
            $display("FAIL midrst_route got=%b/%h/%b want=1/000d1/0",
                     out1_valid, out1_data, out0_valid); end
        drain();
        sent0.delete(); sent1.delete(); recv0.delete(); recv1.delete();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_sel     = 1'($urandom);
            in_last    = ($urandom_range(0, 3) == 0);
            in_data    = N'($urandom);
            out0_ready = ($urandom_range(0, 2) != 0);
            out1_ready = ($urandom_range(0, 2) != 0);
            #1;
            checks++; if (in_ready !== exp_ready()) begin failures++;
                $display("FAIL rand_in_ready cyc=%0d got=%b want=%b", i, in_ready, exp_ready()); end
            checks++; if (out0_valid !== (occ(1'b0) != 0)) begin failures++;
                $display("FAIL rand_out0_valid cyc=%0d got=%b want=%b", i, out0_valid,
                         occ(1'b0) != 0); end
            checks++; if (out1_valid !== (occ(1'b1) != 0)) begin failures++;
                $display("FAIL rand_out1_valid cyc=%0d got=%b want=%b", i, out1_valid,
                         occ(1'b1) != 0); end
            if (occ(1'b0) > 0) begin
                checks++; if ({out0_last, out0_data} !== sent0[recv0.size()]) begin failures++;
                    $display("FAIL rand_out0_head cyc=%0d got=%h want=%h", i,
                             {out0_last, out0_data}, sent0[recv0.size()]); end
            end
            if (occ(1'b1) > 0) begin
                checks++; if ({out1_last, out1_data} !== sent1[recv1.size()]) begin failures++;
                    $display("FAIL rand_out1_head cyc=%0d got=%h want=%h", i,
                             {out1_last, out1_data}, sent1[recv1.size()]); end
            end
            tick();
        end
        drain();
        checks++; if (occ(1'b0) != 0 || occ(1'b1) != 0) begin failures++;
            $display("FAIL rand_drain got=%0d/%0d want=0/0", occ(1'b0), occ(1'b1)); end
    endtask

`ifdef STREAM_DEMUX2_PKTCNT_EN
    task automatic test_pktcnt_wrap();
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_sel = 1'b0; in_last = 1'b1; in_data = N'(i);
            tick();
        end
        drain();
        checks++; if (pkt_cnt0 !== CW'(1)) begin failures++;
            $display("FAIL pktcnt0_wrap got=%0d want=1", pkt_cnt0); end
        checks++; if (pkt_cnt1 !== CW'(0)) begin failures++;
            $display("FAIL pktcnt1 got=%0d want=0", pkt_cnt1); end
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_sel = 1'b0; in_data = '0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        test_reset();
        test_single_beat();
        test_packet_hold();
        test_backpressure();
        test_throughput();
        test_mid_reset();
        test_random();
`ifdef STREAM_DEMUX2_PKTCNT_EN
        test_pktcnt_wrap();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
